// File: rtl/raster_line_engine_if.sv
// raster_line_engine_if: clipper line-pull bus plus framebuffer write port
interface raster_line_engine_if #(
  parameter int FB_AW = 19
);
  logic [9:0]       x0_in;
  logic [9:0]       y0_in;
  logic [9:0]       x1_in;
  logic [9:0]       y1_in;
  logic [2:0]       color_in;
  logic             vld;
  logic             end_of_obj;
  logic             raster_ready;
  logic             fb_we;
  logic [FB_AW-1:0] fb_addr;
  logic [2:0]       fb_data;
  logic             fb_stall;
  modport master (
    output x0_in, y0_in, x1_in, y1_in, color_in, vld, end_of_obj, fb_stall,
    input  raster_ready, fb_we, fb_addr, fb_data
  );
  modport slave (
    input  x0_in, y0_in, x1_in, y1_in, color_in, vld, end_of_obj, fb_stall,
    output raster_ready, fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/raster_line_engine.sv
// raster_line_engine: pulls clipped lines and rasterizes them (Bresenham, 1 px/cycle) into the framebuffer.
// Optional macro RASTER_BOUNDS_CHECK_EN suppresses off-screen pixels and adds sticky oob_err.
module raster_line_engine #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int FB_AW = 19
) (
  input  logic                 clk,
  input  logic                 rst_n,
  raster_line_engine_if.slave  bus,
  output logic                 busy,
  output logic                 obj_done,
  output logic                 ovf_err
`ifdef RASTER_BOUNDS_CHECK_EN
  ,
  output logic                 oob_err
`endif
);
  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;
  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] y0;
    logic [9:0] x1;
    logic [9:0] y1;
    logic [2:0] color;
  } line_t;

  if (FB_AW < $clog2(H_RES * V_RES)) begin : g_bad_aw
    $error("FB_AW too small for H_RES*V_RES");
  end

  state_t             state_q, state_d;
  line_t              pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic [9:0]         cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [9:0]         end_x_q, end_x_d, end_y_q, end_y_d;
  logic [2:0]         color_q, color_d;
  logic               sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [11:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic               eoo_prev_q, eoo_seen_q, eoo_seen_d;
  logic               ovf_q, ovf_d;
  logic signed [11:0] dx_raw, dy_raw, dx_abs, dy_neg;
  logic signed [12:0] e2, dx_w, dy_w;
  logic               draw, at_end;
  logic [FB_AW-1:0]   x_w, y_w;

  assign draw     = state_q == DRAW;
  assign at_end   = cur_x_q == end_x_q && cur_y_q == end_y_q;
  assign busy     = state_q != IDLE || pend_vld_q;
  assign obj_done = eoo_seen_q && state_q == IDLE && !pend_vld_q && !bus.vld;
  assign ovf_err  = ovf_q;

  // A rise seen while a completion is already pending is absorbed; a fall does not cancel it.
  assign eoo_seen_d = obj_done ? 1'b0 : eoo_seen_q | (bus.end_of_obj & !eoo_prev_q);

  // Only one line can be in flight: no new pop while the slot is full or a line is arriving.
  assign bus.raster_ready = !pend_vld_q && !bus.vld;
  assign bus.fb_data      = color_q;
  assign x_w              = FB_AW'(cur_x_q);
  assign y_w              = FB_AW'(cur_y_q);
  assign bus.fb_addr      = (H_RES == 640) ? (y_w << 9) + (y_w << 7) + x_w
                                           : y_w * FB_AW'(H_RES) + x_w;

`ifdef RASTER_BOUNDS_CHECK_EN
  logic oob, oob_q;
  assign oob       = {1'b0, cur_x_q} >= 11'(H_RES) || {1'b0, cur_y_q} >= 11'(V_RES);
  assign bus.fb_we = draw & !oob;
  assign oob_err   = oob_q;
  // Sticky flag for the first off-screen pixel that was suppressed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) oob_q <= 1'b0;
    else        oob_q <= oob_q | (draw & oob);
`else
  assign bus.fb_we = draw;
`endif

  // Next-state, Bresenham walk and pending-slot capture
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    end_x_d    = end_x_q;
    end_y_d    = end_y_q;
    color_d    = color_q;
    sx_neg_d   = sx_neg_q;
    sy_neg_d   = sy_neg_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    dx_raw     = $signed({2'b0, pend_q.x1}) - $signed({2'b0, pend_q.x0});
    dy_raw     = $signed({2'b0, pend_q.y1}) - $signed({2'b0, pend_q.y0});
    dx_abs     = dx_raw[11] ? -dx_raw : dx_raw;
    dy_neg     = dy_raw[11] ? dy_raw : -dy_raw;
    e2         = 13'(err_q) <<< 1;
    dx_w       = 13'(dx_q);
    dy_w       = 13'(dy_q);
    unique case (state_q)
      IDLE: state_d = pend_vld_q ? SETUP : IDLE;
      SETUP: begin
        cur_x_d    = pend_q.x0;
        cur_y_d    = pend_q.y0;
        end_x_d    = pend_q.x1;
        end_y_d    = pend_q.y1;
        color_d    = pend_q.color;
        sx_neg_d   = !(pend_q.x0 < pend_q.x1);
        sy_neg_d   = !(pend_q.y0 < pend_q.y1);
        dx_d       = dx_abs;
        dy_d       = dy_neg;
        err_d      = dx_abs + dy_neg;
        pend_vld_d = 1'b0;
        state_d    = DRAW;
      end
      DRAW: if (!bus.fb_stall) begin
        if (at_end) state_d = pend_vld_q ? SETUP : IDLE;
        else begin
          cur_x_d = (e2 >= dy_w) ? (sx_neg_q ? cur_x_q - 10'd1 : cur_x_q + 10'd1) : cur_x_q;
          cur_y_d = (e2 <= dx_w) ? (sy_neg_q ? cur_y_q - 10'd1 : cur_y_q + 10'd1) : cur_y_q;
          err_d   = err_q + ((e2 >= dy_w) ? dy_q : 12'sd0) + ((e2 <= dx_w) ? dx_q : 12'sd0);
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.vld) begin
      if (pend_vld_q) ovf_d = 1'b1;
      else begin
        pend_d     = {bus.x0_in, bus.y0_in, bus.x1_in, bus.y1_in, bus.color_in};
        pend_vld_d = 1'b1;
      end
    end
  end

  // State and datapath registers; async reset aborts any line in progress
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      end_x_q    <= '0;
      end_y_q    <= '0;
      color_q    <= '0;
      sx_neg_q   <= 1'b0;
      sy_neg_q   <= 1'b0;
      dx_q       <= '0;
      dy_q       <= '0;
      err_q      <= '0;
      eoo_prev_q <= 1'b0;
      eoo_seen_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      end_x_q    <= end_x_d;
      end_y_q    <= end_y_d;
      color_q    <= color_d;
      sx_neg_q   <= sx_neg_d;
      sy_neg_q   <= sy_neg_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      err_q      <= err_d;
      eoo_prev_q <= bus.end_of_obj;
      eoo_seen_q <= eoo_seen_d;
      ovf_q      <= ovf_d;
    end
endmodule
